// File: rtl/snitch_icache_pkg.sv
// Shared types for the icache data array: geometry, per-set power FSM states, and the macro-count helper.
// No logic and no latency: types and constants only.
// No handshake: nothing here takes part in flow control.
package snitch_icache_pkg;

    typedef struct packed {
        int unsigned SET_COUNT;
        int unsigned LINE_COUNT;
        int unsigned LINE_WIDTH;
        int unsigned COUNT_ALIGN;
    } config_t;

    localparam config_t DEFAULT_CFG = '{
        SET_COUNT:   2,
        LINE_COUNT:  128,
        LINE_WIDTH:  256,
        COUNT_ALIGN: 7
    };

    typedef enum logic [1:0] {
        AWAKE  = 2'd0,
        SLEEP  = 2'd1,
        WAKING = 2'd2
    } data_fsm_e;

    function automatic int unsigned macro_count(input int unsigned line_w, input int unsigned macro_w);
        return line_w / macro_w;
    endfunction

endpackage

// File: rtl/snitch_icache_data_macro.sv
// One single-port SRAM macro with a retention sleep pin. While the pin is high, no access reaches the array.
// Read data is registered one cycle after the access and held until the next read.
// No handshake: the caller must not issue an access while the macro sleeps.
module snitch_icache_data_macro #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned AW    = 7,
    parameter int unsigned DW    = 128,
    parameter type         cfg_t = logic
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  cfg_t          i_cfg,
    input  logic          i_sleep,
    input  logic          i_req,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;
    logic          w_en;
    logic          w_unused_cfg;

    // The behavioural model has no trim or margin knobs, so the configuration goes nowhere.
    assign w_unused_cfg = ^i_cfg;
    assign w_en         = i_req & ~i_sleep;

    always_ff @(posedge clk_i) begin
        if (w_en && i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rdata <= '0;
        end else if (w_en && !i_we) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/snitch_icache_data_banked.sv
// Banked icache data array. Each set is built from several macros and has its own idle-sleep/wake FSM.
// Read response comes 1 cycle after accept, or 2 cycles with OUT_REG. Back-to-back reads run at full rate.
// req_ready_o drops while any selected set is asleep or waking. The response has no backpressure.
module snitch_icache_data_banked
    import snitch_icache_pkg::*;
#(
    parameter config_t     CFG             = DEFAULT_CFG,
    parameter int unsigned MACRO_WIDTH     = 128,
    parameter bit          OUT_REG         = 1'b0,
    parameter int unsigned IDLE_CYCLES     = 16,
    parameter int unsigned WAKE_CYCLES     = 2,
    parameter type         sram_cfg_data_t = logic
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  sram_cfg_data_t                          sram_cfg_data_i,
    input  logic                                    sleep_en_i,
    input  logic                                    req_valid_i,
    output logic                                    req_ready_o,
    input  logic                                    req_write_i,
    input  logic [CFG.SET_COUNT-1:0]                req_set_en_i,
    input  logic [CFG.COUNT_ALIGN-1:0]              req_addr_i,
    input  logic [CFG.SET_COUNT*CFG.LINE_WIDTH-1:0] req_wdata_i,
    output logic                                    rsp_valid_o,
    output logic [CFG.SET_COUNT*CFG.LINE_WIDTH-1:0] rsp_rdata_o,
    output logic [CFG.SET_COUNT-1:0]                set_asleep_o
);

    localparam int unsigned SC = CFG.SET_COUNT;
    localparam int unsigned LW = CFG.LINE_WIDTH;
    localparam int unsigned MC = macro_count(LW, MACRO_WIDTH);
    localparam int unsigned IW = $clog2(IDLE_CYCLES + 1);
    localparam int unsigned WW = $clog2(WAKE_CYCLES + 1);

    if ((LW % MACRO_WIDTH) != 0 || IDLE_CYCLES < 1 || WAKE_CYCLES < 1) begin : g_bad_cfg
        $error("snitch_icache_data_banked: illegal LINE_WIDTH/MACRO_WIDTH/IDLE_CYCLES/WAKE_CYCLES");
    end

    logic [SC-1:0]    w_awake;
    logic [SC-1:0]    w_set_req;
    logic [SC-1:0]    w_set_acc;
    logic             w_accept;
    logic             w_rd_accept;
    logic [SC*LW-1:0] w_rdata;
    logic             r_rsp_vld1;

    assign req_ready_o = &(w_awake | ~req_set_en_i);
    assign w_accept    = req_valid_i & req_ready_o;
    assign w_set_req   = {SC{req_valid_i}} & req_set_en_i;
    assign w_set_acc   = {SC{w_accept}} & req_set_en_i;
    assign w_rd_accept = w_accept & ~req_write_i & (|req_set_en_i);

    for (genvar s = 0; s < SC; s++) begin : g_set
        data_fsm_e     r_state;
        logic [IW-1:0] r_idle_cnt;
        logic [WW-1:0] r_wake_cnt;
        logic          w_sleep;

        assign w_awake[s]      = (r_state == AWAKE);
        assign set_asleep_o[s] = (r_state == SLEEP);
        assign w_sleep         = (r_state != AWAKE);

        // Only sleep on a cycle nobody asks for the set, so an accepted access never meets a sleeping macro.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_state    <= AWAKE;
                r_idle_cnt <= '0;
                r_wake_cnt <= '0;
            end else begin
                case (r_state)
                    AWAKE: begin
                        if (w_set_acc[s]) begin
                            r_idle_cnt <= '0;
                        end else if (sleep_en_i && !w_set_req[s] &&
                                     r_idle_cnt == IW'(IDLE_CYCLES - 1)) begin
                            r_state    <= SLEEP;
                            r_idle_cnt <= '0;
                        end else if (r_idle_cnt != IW'(IDLE_CYCLES - 1)) begin
                            r_idle_cnt <= r_idle_cnt + IW'(1);
                        end
                    end
                    SLEEP: begin
                        if (w_set_req[s] || !sleep_en_i) begin
                            r_state    <= WAKING;
                            r_wake_cnt <= WW'(WAKE_CYCLES - 1);
                        end
                    end
                    WAKING: begin
                        if (r_wake_cnt == '0) begin
                            r_state <= AWAKE;
                        end else begin
                            r_wake_cnt <= r_wake_cnt - WW'(1);
                        end
                    end
                    default: r_state <= AWAKE;
                endcase
            end
        end

        for (genvar m = 0; m < MC; m++) begin : g_col
            snitch_icache_data_macro #(
                .DEPTH (CFG.LINE_COUNT),
                .AW    (CFG.COUNT_ALIGN),
                .DW    (MACRO_WIDTH),
                .cfg_t (sram_cfg_data_t)
            ) i_macro (
                .clk_i   (clk_i),
                .rst_ni  (rst_ni),
                .i_cfg   (sram_cfg_data_i),
                .i_sleep (w_sleep),
                .i_req   (w_set_acc[s]),
                .i_we    (req_write_i),
                .i_addr  (req_addr_i),
                .i_wdata (req_wdata_i[s*LW + m*MACRO_WIDTH +: MACRO_WIDTH]),
                .o_rdata (w_rdata[s*LW + m*MACRO_WIDTH +: MACRO_WIDTH])
            );
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp_vld1 <= 1'b0;
        end else begin
            r_rsp_vld1 <= w_rd_accept;
        end
    end

    if (OUT_REG) begin : g_out_reg
        logic             r_rsp_vld2;
        logic [SC*LW-1:0] r_rdata;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_rsp_vld2 <= 1'b0;
                r_rdata    <= '0;
            end else begin
                r_rsp_vld2 <= r_rsp_vld1;
                if (r_rsp_vld1) begin
                    r_rdata <= w_rdata;
                end
            end
        end

        assign rsp_valid_o = r_rsp_vld2;
        assign rsp_rdata_o = r_rdata;
    end else begin : g_out_comb
        assign rsp_valid_o = r_rsp_vld1;
        assign rsp_rdata_o = w_rdata;
    end

endmodule

// File: tb/tb_snitch_icache_data_banked.sv
// Directed bench for the banked icache data array: a driver pushes expected reads, and a monitor pops them on rsp_valid_o.
// Covers write/read, full-rate reads, idle sleep, wake stall, partial-set access, sleep disable and reset drop.
module tb_snitch_icache_data_banked;

    localparam bit OUT_REG = 1'b0;
    localparam int LAT     = OUT_REG ? 2 : 1;
    localparam int SC      = 2;
    localparam int LW      = 256;
    localparam int W       = SC * LW;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          sram_cfg_data_i = 1'b0;
    logic          sleep_en_i = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic          req_write_i = 1'b0;
    logic [SC-1:0] req_set_en_i = '0;
    logic [6:0]    req_addr_i = '0;
    logic [W-1:0]  req_wdata_i = '0;
    logic          rsp_valid_o;
    logic [W-1:0]  rsp_rdata_o;
    logic [SC-1:0] set_asleep_o;

    snitch_icache_data_banked #(
        .OUT_REG(OUT_REG)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .sram_cfg_data_i (sram_cfg_data_i),
        .sleep_en_i      (sleep_en_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_write_i     (req_write_i),
        .req_set_en_i    (req_set_en_i),
        .req_addr_i      (req_addr_i),
        .req_wdata_i     (req_wdata_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_rdata_o     (rsp_rdata_o),
        .set_asleep_o    (set_asleep_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [W-1:0] dat;
        logic [W-1:0] msk;
        int           cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    bit   expect_rsp = 1'b1;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    function automatic logic [LW-1:0] pat(input int s, input logic [7:0] a);
        logic [LW-1:0] v;
        v = {32{a}};
        return (s != 0) ? ~v : v;
    endfunction

    function automatic logic [W-1:0] line2(input logic [7:0] a);
        return {pat(1, a), pat(0, a)};
    endfunction

    always @(negedge clk_i) begin : monitor
        exp_t e;
        if (rsp_valid_o) begin
            if (q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_rsp: got rsp_valid at cycle %0d, want no response", cyc);
            end else begin
                e = q.pop_front();
                chk("rsp_data", rsp_rdata_o & e.msk, e.dat & e.msk);
                chk("rsp_latency", W'(cyc - e.cyc), W'(LAT));
            end
        end
    end

    // wd doubles as the expected line for reads; the array ignores write data on reads.
    task automatic do_req(input logic wr, input logic [SC-1:0] se, input logic [6:0] addr,
                          input logic [W-1:0] wd, output int stalls);
        logic [W-1:0] m;
        bit           acc;
        stalls = 0;
        acc    = 1'b0;
        forever begin
            @(negedge clk_i);
            req_valid_i  = 1'b1;
            req_write_i  = wr;
            req_set_en_i = se;
            req_addr_i   = addr;
            req_wdata_i  = wd;
            #1;
            if (req_ready_o) begin
                acc = 1'b1;
                break;
            end
            stalls++;
            if (stalls > 50) begin
                n_chk++;
                $display("FAIL req_timeout: got ready=0 for %0d cycles, want ready", stalls);
                break;
            end
        end
        if (acc && !wr && se != '0 && expect_rsp) begin
            for (int s = 0; s < SC; s++) m[s*LW +: LW] = {LW{se[s]}};
            q.push_back('{dat: wd, msk: m, cyc: cyc});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_i);
            req_valid_i = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500000, want finish");
        $fatal(1);
    end

    initial begin
        int           st;
        int           tot;
        logic [LW-1:0] t;

        repeat (3) @(negedge clk_i);
        chk("rst_ready", W'(req_ready_o), W'(1));
        chk("rst_rsp_valid", W'(rsp_valid_o), W'(0));
        chk("rst_asleep", W'(set_asleep_o), W'(0));
        rst_ni = 1'b1;

        // Write then read one line of set 0.
        t = {32{8'hA5}};
        do_req(1'b1, 2'b01, 7'd5, {{LW{1'b0}}, t}, st);
        do_req(1'b0, 2'b01, 7'd5, {{LW{1'b0}}, t}, st);
        idle(3);

        // Fill every line of both sets, then read them all back at full rate.
        for (int a = 0; a < 128; a++) do_req(1'b1, 2'b11, 7'(a), line2(8'(a)), st);
        tot = 0;
        for (int a = 0; a < 128; a++) begin
            do_req(1'b0, 2'b11, 7'(a), line2(8'(a)), st);
            tot += st;
        end
        chk("b2b_stalls", W'(tot), W'(0));

        // Idle sleep: both sets sleep exactly 16 idle cycles after the last access.
        @(negedge clk_i);
        req_valid_i = 1'b0;
        sleep_en_i  = 1'b1;
        repeat (15) @(negedge clk_i);
        chk("asleep_before_limit", W'(set_asleep_o), W'(0));
        @(negedge clk_i);
        chk("asleep_after_idle", W'(set_asleep_o), W'(2'b11));
        do_req(1'b0, 2'b11, 7'd9, line2(8'd9), st);
        chk("wake_stalls", W'(st), W'(3));

        // Hammer set 1 only: set 0 falls asleep, while set 1 keeps serving without stalls.
        tot = 0;
        for (int i = 0; i < 20; i++) begin
            do_req(1'b0, 2'b10, 7'(i + 20), line2(8'(i + 20)), st);
            tot += st;
        end
        chk("set1_stalls", W'(tot), W'(0));
        @(negedge clk_i);
        chk("set0_asleep_only", W'(set_asleep_o), W'(2'b01));

        // Dropping sleep_en wakes set 0 without any request.
        req_valid_i  = 1'b0;
        sleep_en_i   = 1'b0;
        req_set_en_i = 2'b11;
        @(negedge clk_i);
        chk("wake_asleep_clear", W'(set_asleep_o), W'(0));
        chk("wake_ready_0", W'(req_ready_o), W'(0));
        @(negedge clk_i);
        chk("wake_ready_1", W'(req_ready_o), W'(0));
        @(negedge clk_i);
        chk("wake_ready_2", W'(req_ready_o), W'(1));

        // Reset right after a read accept must swallow the response.
        idle(2);
        expect_rsp = 1'b0;
        do_req(1'b0, 2'b01, 7'd3, line2(8'd3), st);
        @(posedge clk_i);
        #1;
        rst_ni      = 1'b0;
        req_valid_i = 1'b0;
        @(negedge clk_i);
        chk("mid_rst_ready", W'(req_ready_o), W'(1));
        chk("mid_rst_rsp_valid", W'(rsp_valid_o), W'(0));
        chk("mid_rst_asleep", W'(set_asleep_o), W'(0));
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("post_rst_rsp_valid", W'(rsp_valid_o), W'(0));

        idle(4);
        chk("scoreboard_drained", W'(q.size()), W'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
